periph_channel: RTL

Host-side endpoint of one reconfigurable peripheral slot: the opposite end of the peripheral's tx/rx FIFO interface. It accepts addressed USB packets from the packet router, strips the peripheral address, and buffers payloads in a TX FIFO that the peripheral drains. It also buffers payloads produced by the peripheral in an RX FIFO, prepends this slot's address, and presents complete USB packets to the upstream arbiter over a valid/ready handshake.

---
 rtl/periph_channel.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/periph_channel.sv
// periph_channel: host-side endpoint of one reconfigurable peripheral slot.
// Addressed packets from the router are stripped of their address and queued
// in a TX FIFO that the peripheral drains first-word-fall-through. Payloads
// written by the peripheral are queued in an RX FIFO, tagged with this slot's
// address and handed upstream through a single valid/ready output register.
// Optional build macro: PERIPH_CHANNEL_STATS_EN enables the saturating
// drop_count statistics counter; without it drop_count is tied to zero.

module periph_channel #(
   parameter int                PACKET_W    = 32,
   parameter int                ADDR_W      = 3,
   parameter logic [ADDR_W-1:0] PERIPH_ADDR = '0,
   parameter int                DEPTH       = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush,
   input  logic [PACKET_W-1:0]          host_tx_data,
   input  logic                         host_tx_valid,
   output logic                         host_tx_ready,
   output logic [PACKET_W-ADDR_W-1:0]   periph_tx_data,
   output logic                         periph_tx_empty,
   input  logic                         periph_tx_read,
   input  logic [PACKET_W-ADDR_W-1:0]   periph_rx_data,
   input  logic                         periph_rx_valid,
   output logic                         periph_rx_full,
   output logic [PACKET_W-1:0]          host_rx_data,
   output logic                         host_rx_valid,
   input  logic                         host_rx_ready,
   input  logic                         periph_idle,
   output logic                         channel_idle,
   output logic                         rx_overflow,
   output logic [7:0]                   drop_count
);

   localparam int PAYLOAD_W = PACKET_W - ADDR_W;
   localparam int AW        = $clog2(DEPTH);
   localparam int PW        = AW + 1;

   // ---------------------------------------------------------------
   // TX path: router -> FIFO -> peripheral
   // ---------------------------------------------------------------
   logic [PAYLOAD_W-1:0] txMem_q [DEPTH];
   logic [PW-1:0]        txWrPtr_q, txWrPtr_d;
   logic [PW-1:0]        txRdPtr_q, txRdPtr_d;
   logic                 txEmpty;
   logic                 txFull;
   logic                 addrMatch;
   logic                 txAccept;
   logic                 txWrite;
   logic                 txRead;

   // The extra pointer MSB distinguishes a full FIFO from an empty one
   // when the index bits coincide.
   assign txEmpty   = (txWrPtr_q == txRdPtr_q);
   assign txFull    = (txWrPtr_q[AW] != txRdPtr_q[AW]) &&
                      (txWrPtr_q[AW-1:0] == txRdPtr_q[AW-1:0]);
   assign addrMatch = (host_tx_data[PACKET_W-1 -: ADDR_W] == PERIPH_ADDR);

   // A handshake completes for every packet while not full; only packets
   // addressed to this slot are stored, the rest are silently dropped.
   assign txAccept  = host_tx_valid & ~txFull & ~flush;
   assign txWrite   = txAccept & addrMatch;
   assign txRead    = periph_tx_read & ~txEmpty & ~flush;

   assign host_tx_ready   = ~txFull;
   assign periph_tx_empty = txEmpty;
   assign periph_tx_data  = txEmpty ? '0 : txMem_q[txRdPtr_q[AW-1:0]];

   // Next-state for the TX pointers; flush wins over any same-cycle traffic.
   always_comb begin
      txWrPtr_d = txWrPtr_q;
      txRdPtr_d = txRdPtr_q;
      if (flush) begin
         txWrPtr_d = '0;
         txRdPtr_d = '0;
      end else begin
         if (txWrite) txWrPtr_d = txWrPtr_q + PW'(1);
         if (txRead)  txRdPtr_d = txRdPtr_q + PW'(1);
      end
   end

   // TX storage holds no reset; validity is tracked by the pointers alone.
   always_ff @(posedge clk) begin
      if (txWrite) txMem_q[txWrPtr_q[AW-1:0]] <= host_tx_data[PAYLOAD_W-1:0];
   end

   // ---------------------------------------------------------------
   // RX path: peripheral -> FIFO -> output register -> arbiter
   // ---------------------------------------------------------------
   logic [PAYLOAD_W-1:0] rxMem_q [DEPTH];
   logic [PW-1:0]        rxWrPtr_q, rxWrPtr_d;
   logic [PW-1:0]        rxRdPtr_q, rxRdPtr_d;
   logic                 rxEmpty;
   logic                 rxFull;
   logic                 rxWrite;
   logic                 rxOverflowEvent;
   logic                 outLoad;
   logic                 outValid_q, outValid_d;
   logic [PACKET_W-1:0]  outData_q, outData_d;
   logic                 rxOverflow_q, rxOverflow_d;

   assign rxEmpty = (rxWrPtr_q == rxRdPtr_q);
   assign rxFull  = (rxWrPtr_q[AW] != rxRdPtr_q[AW]) &&
                    (rxWrPtr_q[AW-1:0] == rxRdPtr_q[AW-1:0]);

   // Full is judged on registered state only, so a write that arrives while
   // full is refused even if the output stage drains an entry that cycle.
   assign rxWrite         = periph_rx_valid & ~rxFull & ~flush;
   assign rxOverflowEvent = periph_rx_valid &  rxFull & ~flush;

   // The output register refills whenever it is empty or being accepted,
   // which sustains one packet per cycle while the arbiter keeps ready high.
   assign outLoad = ~rxEmpty & (~outValid_q | host_rx_ready) & ~flush;

   assign periph_rx_full = rxFull;
   assign host_rx_valid  = outValid_q;
   assign host_rx_data   = outData_q;
   assign rx_overflow    = rxOverflow_q;

   // Next-state for the RX pointers, the output register and the sticky
   // overflow flag; flush clears everything except the overflow flag.
   always_comb begin
      rxWrPtr_d    = rxWrPtr_q;
      rxRdPtr_d    = rxRdPtr_q;
      outValid_d   = outValid_q;
      outData_d    = outData_q;
      rxOverflow_d = rxOverflow_q | rxOverflowEvent;
      if (flush) begin
         rxWrPtr_d  = '0;
         rxRdPtr_d  = '0;
         outValid_d = 1'b0;
      end else begin
         if (rxWrite) rxWrPtr_d = rxWrPtr_q + PW'(1);
         if (outLoad) begin
            rxRdPtr_d  = rxRdPtr_q + PW'(1);
            outValid_d = 1'b1;
            outData_d  = {PERIPH_ADDR, rxMem_q[rxRdPtr_q[AW-1:0]]};
         end else if (host_rx_ready) begin
            outValid_d = 1'b0;
         end
      end
   end

   // RX storage holds no reset; validity is tracked by the pointers alone.
   always_ff @(posedge clk) begin
      if (rxWrite) rxMem_q[rxWrPtr_q[AW-1:0]] <= periph_rx_data;
   end

   // Channel state registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         txWrPtr_q    <= '0;
         txRdPtr_q    <= '0;
         rxWrPtr_q    <= '0;
         rxRdPtr_q    <= '0;
         outValid_q   <= 1'b0;
         outData_q    <= '0;
         rxOverflow_q <= 1'b0;
      end else begin
         txWrPtr_q    <= txWrPtr_d;
         txRdPtr_q    <= txRdPtr_d;
         rxWrPtr_q    <= rxWrPtr_d;
         rxRdPtr_q    <= rxRdPtr_d;
         outValid_q   <= outValid_d;
         outData_q    <= outData_d;
         rxOverflow_q <= rxOverflow_d;
      end
   end

   // Idle only when nothing is buffered anywhere and the peripheral agrees.
   assign channel_idle = txEmpty & rxEmpty & ~outValid_q & periph_idle;

   // ---------------------------------------------------------------
   // Drop statistics
   // ---------------------------------------------------------------
`ifdef PERIPH_CHANNEL_STATS_EN
   logic       txDrop;
   logic [7:0] dropCount_q, dropCount_d;
   logic [8:0] dropSum;

   assign txDrop = txAccept & ~addrMatch;

   // Address drops and RX overflows can coincide, so up to two events are
   // added per cycle before saturating at the counter maximum.
   always_comb begin
      dropSum     = {1'b0, dropCount_q} + {8'd0, txDrop} + {8'd0, rxOverflowEvent};
      dropCount_d = dropSum[8] ? 8'hFF : dropSum[7:0];
   end

   // Statistics survive flush and are cleared only by reset.
   always_ff @(posedge clk) begin
      if (rst) dropCount_q <= '0;
      else     dropCount_q <= dropCount_d;
   end

   assign drop_count = dropCount_q;
`else
   assign drop_count = 8'd0;
`endif

endmodule
